// File: rtl/norm24_if.sv
// norm24_if: handshake and data bundle between the significand adder, the
// post-add normalizer and the rounder.
//
// Signals (all driven/sampled on the rising edge of the block clock):
//   in_valid  producer -> normalizer  operand presented
//   in_ready  normalizer -> producer  normalizer idle, operand will be taken
//   sig       producer -> normalizer  raw sum, top bit is the adder carry
//   exp       producer -> normalizer  biased exponent of the sum
//   out_valid normalizer -> consumer  result held
//   out_ready consumer -> normalizer  consumer takes the result
//   rslt      normalizer -> consumer  normalized significand (MSB = hidden bit)
//   rexp      normalizer -> consumer  normalized biased exponent
//   zero      normalizer -> consumer  result is exactly zero
//   ovf       normalizer -> consumer  carry normalization overflowed to max exponent
//   shcnt     normalizer -> consumer  total left shifts applied
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A source holds valid and its data stable until that edge; the sink may
// drive ready independently of valid.
//
// Modports: master = operand producer / result consumer (the environment),
//           slave  = the normalizer itself.
interface norm24_if #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 24,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [SIG_W:0]   sig;
    logic [EXP_W-1:0] exp;
    logic             out_valid;
    logic             out_ready;
    logic [SIG_W-1:0] rslt;
    logic [EXP_W-1:0] rexp;
    logic             zero;
    logic             ovf;
    logic [CNT_W-1:0] shcnt;

    modport master (
        output in_valid, sig, exp, out_ready,
        input  in_ready, out_valid, rslt, rexp, zero, ovf, shcnt
    );

    modport slave (
        input  in_valid, sig, exp, out_ready,
        output in_ready, out_valid, rslt, rexp, zero, ovf, shcnt
    );
endinterface

// File: rtl/norm24_seq.sv
// norm24_seq: multi-cycle post-add normalizer for the FP-32 datapath.
//
// Takes the raw significand sum (carry + SIG_W bits) and its biased exponent,
// and left-shifts until the hidden bit is set, decrementing the exponent per
// shift. Carry-out is handled with a single right shift, exp==max passes
// through untouched, a zero sum flags zero, and exhausting the exponent stops
// the shifting and produces a denormal (rexp=0).
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset; aborts any operation in flight
//   bus        norm24_if.slave: in_valid/in_ready/sig/exp on the input side,
//              out_valid/out_ready/rslt/rexp/zero/ovf/shcnt on the output side
//   dbg_state  current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Build option:
//   NORM24_FAST_SHIFT_EN  when defined, SHIFT takes a 4-bit coarse step when
//                         the top nibble is empty and the exponent allows it.
//                         Results are identical, only latency shrinks.
module norm24_seq #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    norm24_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int CNT_W = 5;

    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
`ifdef NORM24_FAST_SHIFT_EN
    localparam logic [EXP_W-1:0] EXP_FOUR = EXP_W'(4);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] wsig_q,  wsig_d;
    logic [EXP_W-1:0] wexp_q,  wexp_d;
    logic [SIG_W-1:0] rslt_q,  rslt_d;
    logic [EXP_W-1:0] rexp_q,  rexp_d;
    logic             zero_q,  zero_d;
    logic             ovf_q,   ovf_d;
    logic [CNT_W-1:0] shcnt_q, shcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wsig_q  <= '0;
            wexp_q  <= '0;
            rslt_q  <= '0;
            rexp_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            shcnt_q <= '0;
        end else begin
            state_q <= state_d;
            wsig_q  <= wsig_d;
            wexp_q  <= wexp_d;
            rslt_q  <= rslt_d;
            rexp_q  <= rexp_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            shcnt_q <= shcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wsig_d  = wsig_q;
        wexp_d  = wexp_q;
        rslt_d  = rslt_q;
        rexp_d  = rexp_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        shcnt_d = shcnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shcnt_d = '0;
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    if (bus.exp == EXP_MAX) begin
                        // Inf/NaN exponent: no normalization, the carry bit is ignored.
                        rslt_d  = bus.sig[SIG_W-1:0];
                        rexp_d  = EXP_MAX;
                        state_d = DONE;
                    end else if (bus.sig[SIG_W]) begin
                        // Carry out: one right shift; the dropped LSB is the rounder's problem.
                        if (bus.exp == EXP_MAX - EXP_ONE) begin
                            rslt_d = '0;
                            rexp_d = EXP_MAX;
                            ovf_d  = 1'b1;
                        end else begin
                            rslt_d = bus.sig[SIG_W:1];
                            rexp_d = bus.exp + EXP_ONE;
                        end
                        state_d = DONE;
                    end else begin
                        wsig_d  = bus.sig[SIG_W-1:0];
                        wexp_d  = bus.exp;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (wsig_q == '0) begin
                    zero_d  = 1'b1;
                    rexp_d  = '0;
                    rslt_d  = '0;
                    state_d = DONE;
                end else if (wsig_q[SIG_W-1]) begin
                    rslt_d  = wsig_q;
                    rexp_d  = wexp_q;
                    state_d = DONE;
                end else if (wexp_q <= EXP_ONE) begin
                    // Exponent exhausted: leave the significand where it is, denormal result.
                    rslt_d  = wsig_q;
                    rexp_d  = '0;
                    state_d = DONE;
`ifdef NORM24_FAST_SHIFT_EN
                end else if ((wsig_q[SIG_W-1 -: 4] == 4'd0) && (wexp_q > EXP_FOUR)) begin
                    // exp>4 guarantees exp stays >=1 afterwards, matching four single steps.
                    wsig_d  = wsig_q << 4;
                    wexp_d  = wexp_q - EXP_FOUR;
                    shcnt_d = shcnt_q + CNT_W'(4);
`endif
                end else begin
                    wsig_d  = wsig_q << 1;
                    wexp_d  = wexp_q - EXP_ONE;
                    shcnt_d = shcnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.rslt      = rslt_q;
    assign bus.rexp      = rexp_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.shcnt     = shcnt_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_norm24_seq.sv
// tb_norm24_seq: directed self-checking bench for norm24_seq.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, well away from the active edge.
module tb_norm24_seq;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    norm24_if bus ();

    norm24_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wait (bounded) for in_ready, then present one operand and hold it through the accept edge.
    task automatic drive_op(input logic [24:0] s, input logic [7:0] e, input string name);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready wait: got %b expected 1", name, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.sig      = s;
        bus.exp      = e;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Called right after the accept edge (+1): counts cycles until out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string name,
                                input logic [23:0] er, input logic [7:0] ee,
                                input logic ez, input logic eo, input logic [4:0] esh,
                                input int lat, input int elat);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid: got %b expected 1", name, bus.out_valid);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        checks++;
        if (bus.rslt !== er) begin
            errors++;
            $display("FAIL %s rslt: got %h expected %h", name, bus.rslt, er);
        end
        checks++;
        if (bus.rexp !== ee) begin
            errors++;
            $display("FAIL %s rexp: got %0d expected %0d", name, bus.rexp, ee);
        end
        checks++;
        if (bus.zero !== ez) begin
            errors++;
            $display("FAIL %s zero: got %b expected %b", name, bus.zero, ez);
        end
        checks++;
        if (bus.ovf !== eo) begin
            errors++;
            $display("FAIL %s ovf: got %b expected %b", name, bus.ovf, eo);
        end
        checks++;
        if (bus.shcnt !== esh) begin
            errors++;
            $display("FAIL %s shcnt: got %0d expected %0d", name, bus.shcnt, esh);
        end
    endtask

    // Take the result and confirm out_valid drops on the following cycle.
    task automatic release_result(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b expected 0/1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic run_op(input string name, input logic [24:0] s, input logic [7:0] e,
                          input logic [23:0] er, input logic [7:0] ee,
                          input logic ez, input logic eo, input logic [4:0] esh,
                          input int elat);
        int lat;
        drive_op(s, e, name);
        wait_valid(lat);
        check_result(name, er, ee, ez, eo, esh, lat, elat);
        release_result(name);
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.sig       = '0;
        bus.exp       = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.rslt !== 24'h0 ||
            bus.rexp !== 8'h0 || bus.zero !== 1'b0 || bus.ovf !== 1'b0 || bus.shcnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b rslt=%h rexp=%h z=%b o=%b sh=%0d expected 1 0 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.rslt, bus.rexp, bus.zero, bus.ovf, bus.shcnt);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_normalize();
        int fast_lat;
        run_op("aligned",   25'h0800000, 8'd127, 24'h800000, 8'd127, 1'b0, 1'b0, 5'd0, 2);
`ifdef NORM24_FAST_SHIFT_EN
        fast_lat = 10;
`else
        fast_lat = 25;
`endif
        run_op("lsb_only",  25'h0000001, 8'd127, 24'h800000, 8'd104, 1'b0, 1'b0, 5'd23, fast_lat);
`ifdef NORM24_FAST_SHIFT_EN
        fast_lat = 4;
`else
        fast_lat = 10;
`endif
        run_op("shift8",    25'h000F000, 8'd100, 24'hF00000, 8'd92,  1'b0, 1'b0, 5'd8, fast_lat);
    endtask

    task automatic test_carry();
        run_op("carry",      25'h1800000, 8'd127, 24'hC00000, 8'd128, 1'b0, 1'b0, 5'd0, 1);
        run_op("carry_ovf",  25'h1000000, 8'd254, 24'h000000, 8'd255, 1'b0, 1'b1, 5'd0, 1);
        run_op("exp_max",    25'h0123456, 8'd255, 24'h123456, 8'd255, 1'b0, 1'b0, 5'd0, 1);
        run_op("exp_max_cy", 25'h1800000, 8'd255, 24'h800000, 8'd255, 1'b0, 1'b0, 5'd0, 1);
    endtask

    task automatic test_zero_denormal();
        run_op("zero",       25'h0000000, 8'd50,  24'h000000, 8'd0, 1'b1, 1'b0, 5'd0, 2);
        run_op("denormal",   25'h0000100, 8'd3,   24'h000400, 8'd0, 1'b0, 1'b0, 5'd2, 4);
        run_op("exp_zero",   25'h0400000, 8'd0,   24'h400000, 8'd0, 1'b0, 1'b0, 5'd0, 2);
    endtask

    // Result held with out_ready low; a new operand offered meanwhile must be ignored.
    task automatic test_hold();
        int lat;
        drive_op(25'h0200000, 8'd10, "hold");
        wait_valid(lat);
        check_result("hold", 24'h800000, 8'd8, 1'b0, 1'b0, 5'd2, lat, 4);
        bus.in_valid = 1'b1;
        bus.sig      = 25'h0000001;
        bus.exp      = 8'd200;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.rslt !== 24'h800000 ||
                bus.rexp !== 8'd8 || bus.shcnt !== 5'd2) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b rslt=%h rexp=%0d sh=%0d expected 1 0 800000 8 2",
                         i, bus.out_valid, bus.in_ready, bus.rslt, bus.rexp, bus.shcnt);
            end
        end
        bus.in_valid = 1'b0;
        release_result("hold");
    endtask

    // Second operand waits on the bus until the first result has been taken.
    task automatic test_back_to_back();
        int lat;
        drive_op(25'h0400000, 8'd50, "b2b_a");
        bus.in_valid = 1'b1;
        bus.sig      = 25'h1400000;
        bus.exp      = 8'd20;
        wait_valid(lat);
        check_result("b2b_a", 24'h800000, 8'd49, 1'b0, 1'b0, 5'd1, lat, 3);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy in_ready: got %b expected 0", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;           // first result taken, back to IDLE
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: got vld=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;           // second operand accepted here
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check_result("b2b_b", 24'hA00000, 8'd21, 1'b0, 1'b0, 5'd0, lat, 1);
        release_result("b2b_b");
    endtask

    task automatic test_reset_mid_op();
        drive_op(25'h0000001, 8'd127, "rst_mid");
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid busy: got rdy=%b state=%0d expected 0 1", bus.in_ready, dbg_state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.shcnt !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid abort: got vld=%b rdy=%b sh=%0d expected 0 1 0",
                     bus.out_valid, bus.in_ready, bus.shcnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid no_output: got out_valid=%b expected 0", bus.out_valid);
            end
        end
        run_op("after_rst", 25'h0100000, 8'd60, 24'h800000, 8'd57, 1'b0, 1'b0, 5'd3,
`ifdef NORM24_FAST_SHIFT_EN
               5
`else
               5
`endif
        );
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_carry();
        test_zero_denormal();
        test_hold();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
